vector_accumulator: RTL and testbench
=====================================

# vector_accumulator

Streaming per-lane accumulator that sits directly downstream of `delay_buffer_1d`. It consumes N aligned lanes of signed PRECISION-bit values, one vector per accepted beat. Over each group of LEN vectors it forms the element-wise sum. Each completed group is presented on a registered output with a valid/ready handshake, so the next layer stage can apply backpressure.

## Interface
- `N`, 4: number of lanes; matches the upstream delay buffer.
- `PRECISION`, 4: input lane width, two's-complement signed.
- `LEN`, 8: vectors per accumulation group, ≥1.
- `ACC_WIDTH`, 16: accumulator and output lane width, signed, ≥ PRECISION.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `idata`  in  [PRECISION-1:0] x [N-1:0]  input vector (unpacked array, same shape as the delay-buffer output).
- `ivalid`  in  1  `idata` valid this cycle.
- `iready`  out  1  block accepts `idata` this cycle.
- `iclear`  in  1  synchronous discard of the partial group.
- `odata`  out  [ACC_WIDTH-1:0] x [N-1:0]  completed group sums.
- `ovalid`  out  1  `odata` holds an unconsumed result.
- `oready`  in  1  downstream consumes `odata`.
- `osat`  out  [N-1:0]  per-lane saturation flag for the presented result; exists only with the macro.

## Operation
- Reset (async, `rst_n`=0):
  - all accumulators = 0, beat counter `cnt` = 0, state = ACCUM.
  - `odata` = 0, `ovalid` = 0, `osat` = 0.
- Beat accepted when `ivalid && iready`.
- State machine:
  - ACCUM: a non-final beat adds the sign-extended `idata[i]` into `acc[i]` and increments `cnt`.
  - Final beat (`cnt == LEN-1`) loads `odata[i] = acc[i] + idata[i]`, sets `ovalid`, clears `acc` to 0 and sets `cnt` to 0; state stays ACCUM.
  - A final beat offered while `ovalid && !oready` cannot complete. `iready` = 0 and state = STALL.
  - STALL: left in the cycle `oready` rises; the final beat is then accepted in that same cycle.
- `iready = !(cnt == LEN-1 && ovalid && !oready)`. This is combinational from `oready`; no other stall source exists.
- Output handshake:
  - `ovalid` clears on `ovalid && oready` unless a new final beat loads in the same cycle; then `ovalid` stays 1 and `odata` is replaced.
  - `odata` is stable while `ovalid && !oready`.
- `iclear`:
  - clears `acc` and `cnt`; no accepted beat is added that cycle.
  - `iclear` takes priority over `ivalid`.
  - `odata`/`ovalid` are unaffected.
- Arithmetic:
  - sign-extend PRECISION to ACC_WIDTH.
  - default wraps modulo 2^ACC_WIDTH.
- LEN = 1: every accepted beat is a final beat.

## Timing
- Latency: the result is visible on `odata`/`ovalid` in the cycle after the final beat is accepted.
- Throughput: one vector per cycle while the downstream keeps up. A result is produced every LEN beats and no bubbles are inserted.
- `ivalid` low holds `acc`/`cnt` unchanged; there is no timeout.
- Reset mid-group drops the partial sum and any pending result immediately, with no clock required.

## Configuration
- `VECTOR_ACC_SAT_EN` defined:
  - each lane add saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - a sticky per-lane flag records any saturation within the group.
  - the flag is copied to `osat` with `odata` and cleared with `acc`.
- Undefined: wrap-around arithmetic; `osat` port and flag logic are absent.

## Structure
- Shared package `linear_pkg`:
  - `acc_state_e` enum {ACCUM, STALL}.
  - a `sat_add` function, used by the lane sub-module when the macro is set.
- Sub-module `lane_accumulator`, instantiated N times (generate):
  - one signed accumulator, sign-extension, optional saturation and sticky flag.
  - inputs: `add_en`, `clr`, `load_out`.
- Top level holds `cnt`, the FSM, the handshake and the output register.

## Test plan
All cases use N=4, PRECISION=4, LEN=8, ACC_WIDTH=16 unless stated.
- Reset sanity: `rst_n` low mid-group after 3 beats, then release → `ovalid`=0, `odata`=0. The next 8 beats of {1,2,3,4} give {8,16,24,32} one cycle after beat 8.
- Signed sum: 8 beats of {-8,7,-1,0} → `odata` = {-64,56,-8,0}.
- Back-to-back groups with `oready`=1: 16 consecutive beats of {1,1,1,1}.
  - `iready` stays 1.
  - `ovalid` pulses at cycles 9 and 17.
  - `odata` = {8,8,8,8} both times.
- Backpressure: `oready`=0 after group 1, then 8 more beats.
  - `iready` drops at `cnt`=7 and group-1 `odata` stays stable.
  - Raising `oready` accepts the final beat in the same cycle.
  - Group 2 appears the next cycle.
- `iclear` after 5 beats of {2,2,2,2}, asserted with `ivalid`=1 → that beat is discarded, and the next 8 beats of {1,1,1,1} give {8,8,8,8}.
- With `VECTOR_ACC_SAT_EN` and ACC_WIDTH=6: 8 beats of {7,-8,1,0} → `odata` = {31,-32,8,0}, `osat` = 4'b0011. Without the macro the same stimulus gives {-8,0,8,0}.

Source files
------------

// File: rtl/linear_pkg.sv
// Shared types and arithmetic helpers for the linear-layer datapath blocks.
// sat_add is only called by lane_accumulator when VECTOR_ACC_SAT_EN is defined.
`timescale 1ns/1ps
package linear_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        STALL = 1'b1
    } acc_state_e;

    localparam int SAT_CALC_W = 64;

    // Operands must already be sign-extended values inside the signed range of 'width'.
    function automatic logic signed [SAT_CALC_W-1:0] sat_add(
        input logic signed [SAT_CALC_W-1:0] a,
        input logic signed [SAT_CALC_W-1:0] b,
        input int unsigned                  width
    );
        logic signed [SAT_CALC_W-1:0] sum;
        logic signed [SAT_CALC_W-1:0] max_v;
        logic signed [SAT_CALC_W-1:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/lane_accumulator.sv
// One signed accumulator lane: sign-extends the input and presents acc + din on sum_out.
// With VECTOR_ACC_SAT_EN the add saturates and a sticky flag is reported on sat_out.
`timescale 1ns/1ps
module lane_accumulator
    import linear_pkg::*;
#(
    parameter int PRECISION = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PRECISION-1:0] din,
    input  logic                 add_en,
    input  logic                 clr,
    input  logic                 load_out,
    output logic [ACC_WIDTH-1:0] sum_out
`ifdef VECTOR_ACC_SAT_EN
    ,
    output logic                 sat_out
`endif
);

    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic signed [ACC_WIDTH-1:0] din_ext;
    logic signed [ACC_WIDTH-1:0] sum_next;

    assign din_ext = ACC_WIDTH'($signed(din));

`ifdef VECTOR_ACC_SAT_EN
    logic signed [SAT_CALC_W-1:0] wide_sum;
    logic signed [SAT_CALC_W-1:0] sat_sum;
    logic                         ovf;
    logic                         sat_reg;

    always_comb begin
        wide_sum = SAT_CALC_W'(acc_reg) + SAT_CALC_W'(din_ext);
        sat_sum  = sat_add(SAT_CALC_W'(acc_reg), SAT_CALC_W'(din_ext), ACC_WIDTH);
        ovf      = (sat_sum != wide_sum);
        sum_next = sat_sum[ACC_WIDTH-1:0];
    end

    // The flag handed to the output includes an overflow on the final beat itself.
    assign sat_out = sat_reg | ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_reg <= 1'b0;
        end else if (clr || load_out) begin
            sat_reg <= 1'b0;
        end else if (add_en) begin
            sat_reg <= sat_reg | ovf;
        end
    end
`else
    assign sum_next = acc_reg + din_ext;
`endif

    assign sum_out = sum_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (clr || load_out) begin
            acc_reg <= '0;
        end else if (add_en) begin
            acc_reg <= sum_next;
        end
    end

endmodule

// File: rtl/vector_accumulator.sv
// Streaming N-lane accumulator: sums LEN input vectors per group and presents each group
// sum on a registered valid/ready output. Define VECTOR_ACC_SAT_EN for saturating lanes + osat.
`timescale 1ns/1ps
module vector_accumulator
    import linear_pkg::*;
#(
    parameter int N         = 4,
    parameter int PRECISION = 4,
    parameter int LEN       = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PRECISION-1:0] idata [N-1:0],
    input  logic                 ivalid,
    output logic                 iready,
    input  logic                 iclear,
    output logic [ACC_WIDTH-1:0] odata [N-1:0],
    output logic                 ovalid,
    input  logic                 oready
`ifdef VECTOR_ACC_SAT_EN
    ,
    output logic [N-1:0]         osat
`endif
);

    localparam int               CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     cnt_next;
    acc_state_e           state_reg;
    acc_state_e           state_next;
    logic                 ovalid_reg;
    logic [ACC_WIDTH-1:0] odata_reg [N-1:0];
    logic [ACC_WIDTH-1:0] lane_sum  [N-1:0];

    logic final_beat;
    logic stall_cond;
    logic beat_accept;
    logic beat_add;
    logic beat_load;

    assign final_beat  = (cnt_reg == CNT_LAST);
    // Only a final beat with an unconsumed result ahead of it has to wait.
    assign stall_cond  = final_beat && ovalid_reg && !oready;
    assign beat_accept = ivalid && iready && !iclear;
    assign beat_add    = beat_accept && !final_beat;
    assign beat_load   = beat_accept && final_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (ivalid && !iclear && stall_cond) state_next = STALL;
            STALL:   if (!(ivalid && !iclear && stall_cond)) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        iready = !stall_cond;
        ovalid = ovalid_reg;
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (iclear || beat_load) begin
            cnt_next = '0;
        end else if (beat_add) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // A new result may replace the one being consumed in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovalid_reg <= 1'b0;
        end else if (beat_load) begin
            ovalid_reg <= 1'b1;
        end else if (oready) begin
            ovalid_reg <= 1'b0;
        end
    end

`ifdef VECTOR_ACC_SAT_EN
    logic [N-1:0] lane_sat;
    logic [N-1:0] osat_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osat_reg <= '0;
        end else if (beat_load) begin
            osat_reg <= lane_sat;
        end
    end

    assign osat = osat_reg;
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        lane_accumulator #(
            .PRECISION (PRECISION),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .din      (idata[gi]),
            .add_en   (beat_add),
            .clr      (iclear),
            .load_out (beat_load),
            .sum_out  (lane_sum[gi])
`ifdef VECTOR_ACC_SAT_EN
            ,
            .sat_out  (lane_sat[gi])
`endif
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                odata_reg[gi] <= '0;
            end else if (beat_load) begin
                odata_reg[gi] <= lane_sum[gi];
            end
        end

        assign odata[gi] = odata_reg[gi];
    end

endmodule

// File: tb/tb_vector_accumulator.sv
// Scoreboard bench for vector_accumulator: directed vectors push expected group sums,
// independent monitors compare each result as it is consumed (VECTOR_ACC_SAT_EN aware).
`timescale 1ns/1ps
module tb_vector_accumulator;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int L  = 8;
    localparam int W  = 16;
    localparam int W2 = 6;

    typedef struct {
        string      name;
        int         v [4];
        logic [3:0] sat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [P-1:0] idata [N-1:0];
    logic         ivalid;
    logic         iready;
    logic         iclear;
    logic [W-1:0] odata [N-1:0];
    logic         ovalid;
    logic         oready;

    logic [P-1:0]  idata2 [N-1:0];
    logic          ivalid2;
    logic          iready2;
    logic          iclear2;
    logic [W2-1:0] odata2 [N-1:0];
    logic          ovalid2;
    logic          oready2;

`ifdef VECTOR_ACC_SAT_EN
    logic [N-1:0] osat;
    logic [N-1:0] osat2;
`endif

    exp_t sb  [$];
    exp_t sb2 [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    vector_accumulator #(.N(N), .PRECISION(P), .LEN(L), .ACC_WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .idata  (idata),
        .ivalid (ivalid),
        .iready (iready),
        .iclear (iclear),
        .odata  (odata),
        .ovalid (ovalid),
        .oready (oready)
`ifdef VECTOR_ACC_SAT_EN
        ,
        .osat   (osat)
`endif
    );

    vector_accumulator #(.N(N), .PRECISION(P), .LEN(L), .ACC_WIDTH(W2)) dut_narrow (
        .clk    (clk),
        .rst_n  (rst_n),
        .idata  (idata2),
        .ivalid (ivalid2),
        .iready (iready2),
        .iclear (iclear2),
        .odata  (odata2),
        .ovalid (ovalid2),
        .oready (oready2)
`ifdef VECTOR_ACC_SAT_EN
        ,
        .osat   (osat2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit narrow, input string name,
                            input int a, input int b, input int c, input int d,
                            input logic [3:0] sat);
        exp_t e;
        e.name = name;
        e.v[0] = a; e.v[1] = b; e.v[2] = c; e.v[3] = d;
        e.sat  = sat;
        if (narrow) sb2.push_back(e);
        else        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && ovalid && oready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                for (int i = 0; i < N; i++)
                    check($sformatf("%s_lane%0d", e.name, i), longint'($signed(odata[i])), e.v[i]);
`ifdef VECTOR_ACC_SAT_EN
                check($sformatf("%s_osat", e.name), osat, e.sat);
`endif
                $display("result %s: {%0d,%0d,%0d,%0d}", e.name, $signed(odata[0]),
                         $signed(odata[1]), $signed(odata[2]), $signed(odata[3]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ovalid2 && oready2) begin
            if (sb2.size() == 0) begin
                check("unexpected_output_narrow", 1, 0);
            end else begin
                exp_t e;
                e = sb2.pop_front();
                for (int i = 0; i < N; i++)
                    check($sformatf("%s_lane%0d", e.name, i), longint'($signed(odata2[i])), e.v[i]);
`ifdef VECTOR_ACC_SAT_EN
                check($sformatf("%s_osat", e.name), osat2, e.sat);
`endif
                $display("result %s: {%0d,%0d,%0d,%0d}", e.name, $signed(odata2[0]),
                         $signed(odata2[1]), $signed(odata2[2]), $signed(odata2[3]));
            end
        end
    end

    task automatic set_vec(input int a, input int b, input int c, input int d);
        idata[0] = a[P-1:0]; idata[1] = b[P-1:0];
        idata[2] = c[P-1:0]; idata[3] = d[P-1:0];
    endtask

    // Presents one vector, waits (bounded) for iready, returns just after the accepting edge.
    task automatic beat(input int a, input int b, input int c, input int d, output int stalls);
        stalls = 0;
        set_vec(a, b, c, d);
        ivalid = 1'b1;
        @(negedge clk);
        while (!iready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (!iready) check("beat_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        ivalid = 1'b0;
    endtask

    task automatic beats(input int n, input int a, input int b, input int c, input int d);
        int s;
        for (int k = 0; k < n; k++) beat(a, b, c, d, s);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        rst_n   = 1'b0;
        ivalid  = 1'b0;
        iclear  = 1'b0;
        oready  = 1'b1;
        set_vec(0, 0, 0, 0);
        ivalid2 = 1'b0;
        iclear2 = 1'b0;
        oready2 = 1'b1;
        for (int i = 0; i < N; i++) idata2[i] = '0;

        idle(3);
        check("reset_ovalid", ovalid, 0);
        check("reset_iready", iready, 1);
        for (int i = 0; i < N; i++) check($sformatf("reset_odata%0d", i), odata[i], 0);
`ifdef VECTOR_ACC_SAT_EN
        check("reset_osat", osat, 0);
`endif
        rst_n = 1'b1;
        idle(1);

        // Signed sum
        push_exp(0, "signed_sum", -64, 56, -8, 0, 4'b0000);
        beats(L, -8, 7, -1, 0);
        check("signed_latency_ovalid", ovalid, 1);
        idle(1);
        check("signed_consumed_ovalid", ovalid, 0);

        // Pending result plus partial group, dropped by asynchronous reset
        oready = 1'b0;
        beats(L, 1, 2, 3, 4);
        check("pending_ovalid", ovalid, 1);
        check("pending_odata3", longint'($signed(odata[3])), 32);
        beats(3, 1, 2, 3, 4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ovalid", ovalid, 0);
        for (int i = 0; i < N; i++) check($sformatf("async_reset_odata%0d", i), odata[i], 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        oready = 1'b1;
        push_exp(0, "after_reset", 8, 16, 24, 32, 4'b0000);
        beats(L, 1, 2, 3, 4);
        check("after_reset_ovalid", ovalid, 1);
        idle(1);

        // Back-to-back groups, no bubbles
        push_exp(0, "b2b_g1", 8, 8, 8, 8, 4'b0000);
        push_exp(0, "b2b_g2", 8, 8, 8, 8, 4'b0000);
        for (int k = 1; k <= 2 * L; k++) begin
            beat(1, 1, 1, 1, s);
            check($sformatf("b2b_stalls_beat%0d", k), s, 0);
            check($sformatf("b2b_ovalid_beat%0d", k), ovalid, (k == L || k == 2 * L) ? 1 : 0);
        end
        idle(1);

        // Backpressure on the final beat of group 2
        push_exp(0, "bp_g1", 8, 8, 8, 8, 4'b0000);
        push_exp(0, "bp_g2", 16, 16, 16, 16, 4'b0000);
        oready = 1'b0;
        beats(L, 1, 1, 1, 1);
        beats(L - 1, 2, 2, 2, 2);
        set_vec(2, 2, 2, 2);
        ivalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_iready_low%0d", k), iready, 0);
            check($sformatf("bp_hold_odata0_%0d", k), longint'($signed(odata[0])), 8);
            check($sformatf("bp_hold_ovalid_%0d", k), ovalid, 1);
        end
        @(posedge clk);
        #1;
        oready = 1'b1;
        #1;
        check("bp_iready_comb", iready, 1);
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        check("bp_g2_ovalid", ovalid, 1);
        idle(1);
        check("bp_drained_ovalid", ovalid, 0);

        // iclear discards the partial group and the beat offered with it
        beats(5, 2, 2, 2, 2);
        set_vec(2, 2, 2, 2);
        ivalid = 1'b1;
        iclear = 1'b1;
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        iclear = 1'b0;
        check("clear_ovalid", ovalid, 0);
        push_exp(0, "after_clear", 8, 8, 8, 8, 4'b0000);
        beats(L, 1, 1, 1, 1);
        check("after_clear_ovalid", ovalid, 1);
        idle(1);

        // Narrow accumulator: saturation or wrap depending on build
`ifdef VECTOR_ACC_SAT_EN
        push_exp(1, "narrow_sat", 31, -32, 8, 0, 4'b0011);
`else
        push_exp(1, "narrow_wrap", -8, 0, 8, 0, 4'b0000);
`endif
        for (int k = 0; k < L; k++) begin
            int a = 7;
            int b = -8;
            int c = 1;
            idata2[0] = a[P-1:0];
            idata2[1] = b[P-1:0];
            idata2[2] = c[P-1:0];
            idata2[3] = '0;
            ivalid2 = 1'b1;
            @(posedge clk);
            #1;
        end
        ivalid2 = 1'b0;
        check("narrow_ovalid", ovalid2, 1);
        idle(3);

        check("scoreboard_drained", sb.size() + sb2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
